// File: rtl/conv2d_engine_pkg.sv
// conv_pkg: shared types and elaboration-time helpers for the conv2d_engine slice.
//   conv_state_t : engine FSM states
//   clog2        : ceiling log2 of a positive integer (0 for values <= 1)
//   idx_width    : bits needed to index 'depth' entries, never less than 1
//   acc_width    : result width that cannot overflow for a K x K correlation
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_K   = 3'd1,
        LOAD_IMG = 3'd2,
        COMPUTE  = 3'd3,
        HOLD     = 3'd4,
        FINISH   = 3'd5
    } conv_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 32'sd1;
            end
        end
        return result;
    endfunction

    function automatic int idx_width(input int depth);
        return (depth <= 32'sd1) ? 32'sd1 : clog2(depth);
    endfunction

    // Pixel is widened by one bit so it stays non-negative in the signed product;
    // the log term covers the growth from summing K*K products.
    function automatic int acc_width(input int data_w, input int coef_w, input int k);
        return data_w + 32'sd1 + coef_w + clog2(k * k);
    endfunction

endpackage

// File: rtl/conv2d_engine_mac.sv
// conv_mac: registered signed multiply-accumulate.
//   clk, rst : clock, synchronous active-low reset
//   clr      : start a new sum with this cycle's product (ignored unless en)
//   en       : accumulate this cycle's product
//   a, b     : signed operands
//   acc      : running sum including the current cycle's product (the value
//              the accumulator register takes at the next edge)
module conv_mac
    import conv_pkg::*;
#(
    parameter int A_W   = 9,
    parameter int B_W   = 8,
    parameter int ACC_W = 21
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    // Product and next accumulator value
    always_comb begin
        prod_s     = P_W'(a) * P_W'(b);
        prod_ext_s = ACC_W'(prod_s);
        if (en) begin
            if (clr) begin
                acc_d = prod_ext_s;
            end else begin
                acc_d = acc_q + prod_ext_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= {ACC_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_d;

endmodule

// File: rtl/conv2d_engine.sv
// conv2d_engine: buffers an IMG_H x IMG_W unsigned image and a K x K signed kernel,
// then streams the valid-region correlation map row-major, one kernel tap per cycle.
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   start                           job start pulse, honoured only when idle
//   coef_valid/coef_data/coef_ready kernel load stream, row-major taps
//   pix_valid/pix_data/pix_ready    image load stream, row-major pixels
//   out_valid/out_data/out_last     result stream, out_ready is downstream backpressure
//   out_ready
//   busy                            high whenever a job is in flight
//   done                            one-cycle pulse after the final result handshake
// Build option: define CONV_RELU_EN to clamp negative results to zero.
module conv2d_engine
    import conv_pkg::*;
#(
    parameter int   IMG_W  = 5,
    parameter int   IMG_H  = 5,
    parameter int   K      = 3,
    parameter int   DATA_W = 8,
    parameter int   COEF_W = 8,
    localparam int  ACC_W  = acc_width(DATA_W, COEF_W, K)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     coef_valid,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     coef_ready,
    input  logic                     pix_valid,
    input  logic [DATA_W-1:0]        pix_data,
    output logic                     pix_ready,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int KN   = K * K;
    localparam int PN   = IMG_W * IMG_H;
    localparam int OW   = IMG_W - K + 1;
    localparam int OH   = IMG_H - K + 1;
    localparam int KA_W = idx_width(KN);
    localparam int PA_W = idx_width(PN);
    localparam int T_W  = idx_width(K);
    localparam int R_W  = idx_width(OH);
    localparam int C_W  = idx_width(OW);

    conv_state_t state_q, state_d;
    logic [PA_W-1:0]         ld_cnt_q, ld_cnt_d;
    logic [T_W-1:0]          tap_i_q, tap_i_d;
    logic [T_W-1:0]          tap_j_q, tap_j_d;
    logic [R_W-1:0]          out_r_q, out_r_d;
    logic [C_W-1:0]          out_c_q, out_c_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    coef_ready_q, coef_ready_d;
    logic                    pix_ready_q, pix_ready_d;

    logic signed [COEF_W-1:0] kern_mem [KN];
    logic [DATA_W-1:0]        pix_mem  [PN];

    logic                    k_we_s;
    logic                    p_we_s;
    logic [KA_W-1:0]         k_addr_s;
    logic [PA_W-1:0]         p_addr_s;
    logic signed [DATA_W:0]  pix_ext_s;
    logic signed [COEF_W-1:0] coef_s;
    logic                    mac_en_s;
    logic                    mac_clr_s;
    logic signed [ACC_W-1:0] mac_sum_s;
    logic signed [ACC_W-1:0] result_s;
    logic                    last_tap_s;
    logic                    last_out_s;

    // Buffer read addresses for the current tap and the MAC operands
    always_comb begin
        k_addr_s  = KA_W'(int'(tap_i_q) * K + int'(tap_j_q));
        p_addr_s  = PA_W'((int'(out_r_q) + int'(tap_i_q)) * IMG_W
                          + int'(out_c_q) + int'(tap_j_q));
        // Zero-extend so an unsigned pixel never reads as negative
        pix_ext_s = {1'b0, pix_mem[p_addr_s]};
        coef_s    = kern_mem[k_addr_s];
        last_tap_s = (tap_i_q == T_W'(K - 1)) && (tap_j_q == T_W'(K - 1));
        last_out_s = (out_r_q == R_W'(OH - 1)) && (out_c_q == C_W'(OW - 1));
    end

    // Optional clamp applied to the finished sum before it is registered
    always_comb begin
`ifdef CONV_RELU_EN
        if (mac_sum_s[ACC_W-1]) begin
            result_s = {ACC_W{1'b0}};
        end else begin
            result_s = mac_sum_s;
        end
`else
        result_s = mac_sum_s;
`endif
    end

    conv_mac #(
        .A_W   (DATA_W + 1),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr_s),
        .en  (mac_en_s),
        .a   (pix_ext_s),
        .b   (coef_s),
        .acc (mac_sum_s)
    );

    // FSM next-state, counters and output-register next values
    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        tap_i_d     = tap_i_q;
        tap_j_d     = tap_j_q;
        out_r_d     = out_r_q;
        out_c_d     = out_c_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        k_we_s      = 1'b0;
        p_we_s      = 1'b0;
        mac_en_s    = 1'b0;
        mac_clr_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD_K;
                    ld_cnt_d = {PA_W{1'b0}};
                    tap_i_d  = {T_W{1'b0}};
                    tap_j_d  = {T_W{1'b0}};
                    out_r_d  = {R_W{1'b0}};
                    out_c_d  = {C_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end

            LOAD_K: begin
                if (coef_valid && coef_ready_q) begin
                    k_we_s = 1'b1;
                    if (ld_cnt_q == PA_W'(KN - 1)) begin
                        ld_cnt_d = {PA_W{1'b0}};
                        state_d  = LOAD_IMG;
                    end else begin
                        ld_cnt_d = ld_cnt_q + PA_W'(1'b1);
                    end
                end else begin
                    ld_cnt_d = ld_cnt_q;
                end
            end

            LOAD_IMG: begin
                if (pix_valid && pix_ready_q) begin
                    p_we_s = 1'b1;
                    if (ld_cnt_q == PA_W'(PN - 1)) begin
                        ld_cnt_d = {PA_W{1'b0}};
                        state_d  = COMPUTE;
                    end else begin
                        ld_cnt_d = ld_cnt_q + PA_W'(1'b1);
                    end
                end else begin
                    ld_cnt_d = ld_cnt_q;
                end
            end

            COMPUTE: begin
                mac_en_s  = 1'b1;
                mac_clr_s = (tap_i_q == {T_W{1'b0}}) && (tap_j_q == {T_W{1'b0}});
                if (last_tap_s) begin
                    // mac_sum_s already includes this final tap
                    tap_i_d     = {T_W{1'b0}};
                    tap_j_d     = {T_W{1'b0}};
                    out_data_d  = result_s;
                    out_valid_d = 1'b1;
                    out_last_d  = last_out_s;
                    state_d     = HOLD;
                end else if (tap_j_q == T_W'(K - 1)) begin
                    tap_j_d = {T_W{1'b0}};
                    tap_i_d = tap_i_q + T_W'(1'b1);
                end else begin
                    tap_j_d = tap_j_q + T_W'(1'b1);
                end
            end

            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else if (out_c_q == C_W'(OW - 1)) begin
                        out_c_d = {C_W{1'b0}};
                        out_r_d = out_r_q + R_W'(1'b1);
                        state_d = COMPUTE;
                    end else begin
                        out_c_d = out_c_q + C_W'(1'b1);
                        state_d = COMPUTE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d != IDLE);
        coef_ready_d = (state_d == LOAD_K);
        pix_ready_d  = (state_d == LOAD_IMG);
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            ld_cnt_q     <= {PA_W{1'b0}};
            tap_i_q      <= {T_W{1'b0}};
            tap_j_q      <= {T_W{1'b0}};
            out_r_q      <= {R_W{1'b0}};
            out_c_q      <= {C_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= {ACC_W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            coef_ready_q <= 1'b0;
            pix_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            tap_i_q      <= tap_i_d;
            tap_j_q      <= tap_j_d;
            out_r_q      <= out_r_d;
            out_c_q      <= out_c_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            coef_ready_q <= coef_ready_d;
            pix_ready_q  <= pix_ready_d;
        end
    end

    // Kernel buffer write port (contents need no reset)
    always_ff @(posedge clk) begin
        if (k_we_s) begin
            kern_mem[KA_W'(ld_cnt_q)] <= coef_data;
        end
    end

    // Image buffer write port (contents need no reset)
    always_ff @(posedge clk) begin
        if (p_we_s) begin
            pix_mem[ld_cnt_q] <= pix_data;
        end
    end

    assign coef_ready = coef_ready_q;
    assign pix_ready  = pix_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
